// File: rtl/cache_ctrl_pkg.sv
// Shared types and defaults for the direct-mapped write-through cache controller.
package cache_ctrl_pkg;

    localparam int LINES_LOG2_DEF = 4;
    localparam int ADDR_WIDTH_DEF = 32;
    localparam int DATA_W         = 32;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RD_MISS = 2'd1,
        S_WR_THRU = 2'd2,
        S_DONE    = 2'd3
    } state_e;

endpackage

// File: rtl/cache_ctrl_line_store.sv
// Line storage: valid/tag/data arrays, asynchronous lookup port and one synchronous write port.
module cache_ctrl_line_store
    import cache_ctrl_pkg::*;
#(
    parameter int LINES_LOG2 = LINES_LOG2_DEF,
    parameter int TAG_W      = ADDR_WIDTH_DEF - LINES_LOG2_DEF - 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [LINES_LOG2-1:0] rd_idx,
    output logic                  rd_valid,
    output logic [TAG_W-1:0]      rd_tag,
    output logic [DATA_W-1:0]     rd_data,
    input  logic                  we,
    input  logic [LINES_LOG2-1:0] wr_idx,
    input  logic [TAG_W-1:0]      wr_tag,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic                  set_valid
);

    localparam int LINES = 1 << LINES_LOG2;

    logic [LINES-1:0]  valid_q;
    logic [TAG_W-1:0]  tag_mem  [LINES];
    logic [DATA_W-1:0] data_mem [LINES];

    // Only the valid bits are reset; tag/data contents are meaningless until filled.
    for (genvar gi = 0; gi < LINES; gi++) begin : g_valid
        always_ff @(posedge clk) begin
            if (rst) begin
                valid_q[gi] <= 1'b0;
            end else if (we && set_valid && (wr_idx == LINES_LOG2'(gi))) begin
                valid_q[gi] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            tag_mem[wr_idx]  <= wr_tag;
            data_mem[wr_idx] <= wr_data;
        end
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_mem[rd_idx];
    assign rd_data  = data_mem[rd_idx];

endmodule

// File: rtl/cache_ctrl.sv
// Direct-mapped, one-word-line, write-through/no-allocate cache between CPU and a slow word RAM.
module cache_ctrl
    import cache_ctrl_pkg::*;
#(
    parameter int LINES_LOG2 = LINES_LOG2_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_W-1:0]     cpu_din,
    output logic [DATA_W-1:0]     cpu_dout,
    output logic                  cpu_stall,
    output logic                  mem_cs,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_W-1:0]     mem_din,
    input  logic [DATA_W-1:0]     mem_dout,
    input  logic                  mem_ack
);

    localparam int TAG_W = ADDR_WIDTH - LINES_LOG2 - 2;

    state_e                  state_q;
    logic                    mem_cs_q;
    logic                    mem_we_q;
    logic [ADDR_WIDTH-1:0]   mem_addr_q;
    logic [DATA_W-1:0]       mem_din_q;
    logic [DATA_W-1:0]       rdata_q;

    logic [ADDR_WIDTH-3:0]   look_word;
    logic [LINES_LOG2-1:0]   look_idx;
    logic [TAG_W-1:0]        look_tag;
    logic                    line_valid;
    logic [TAG_W-1:0]        line_tag;
    logic [DATA_W-1:0]       line_data;
    logic                    hit;
    logic                    is_idle;
    logic                    fill_we;
    logic [DATA_W-1:0]       fill_data;
    logic                    unused_addr_bits;

    assign unused_addr_bits = ^cpu_addr[1:0];

    // While a RAM transaction is open the latched address drives the lookup.
    assign is_idle   = (state_q == S_IDLE);
    assign look_word = is_idle ? cpu_addr[ADDR_WIDTH-1:2] : mem_addr_q[ADDR_WIDTH-1:2];
    assign look_idx  = look_word[LINES_LOG2-1:0];
    assign look_tag  = look_word[ADDR_WIDTH-3:LINES_LOG2];
    assign hit       = line_valid && (line_tag == look_tag);

    assign fill_we   = !rst && mem_ack &&
                       ((state_q == S_RD_MISS) || ((state_q == S_WR_THRU) && hit));
    assign fill_data = (state_q == S_RD_MISS) ? mem_dout : mem_din_q;

    cache_ctrl_line_store #(
        .LINES_LOG2 (LINES_LOG2),
        .TAG_W      (TAG_W)
    ) u_store (
        .clk       (clk),
        .rst       (rst),
        .rd_idx    (look_idx),
        .rd_valid  (line_valid),
        .rd_tag    (line_tag),
        .rd_data   (line_data),
        .we        (fill_we),
        .wr_idx    (look_idx),
        .wr_tag    (look_tag),
        .wr_data   (fill_data),
        .set_valid (state_q == S_RD_MISS)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            mem_cs_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
            rdata_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cpu_req && (cpu_we || !hit)) begin
                        mem_cs_q   <= 1'b1;
                        mem_we_q   <= cpu_we;
                        mem_addr_q <= {cpu_addr[ADDR_WIDTH-1:2], 2'b00};
                        if (cpu_we) begin
                            mem_din_q <= cpu_din;
                        end
                        state_q    <= cpu_we ? S_WR_THRU : S_RD_MISS;
                    end
                end
                S_RD_MISS, S_WR_THRU: begin
                    if (mem_ack) begin
                        mem_cs_q <= 1'b0;
                        mem_we_q <= 1'b0;
                        if (state_q == S_RD_MISS) begin
                            rdata_q <= mem_dout;
                        end
                        state_q  <= S_DONE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign cpu_stall = !rst && cpu_req && !(is_idle && !cpu_we && hit) && (state_q != S_DONE);
    assign cpu_dout  = (is_idle && hit)      ? line_data :
                       (state_q == S_DONE)   ? rdata_q   : '0;

    assign mem_cs   = mem_cs_q;
    assign mem_we   = mem_we_q;
    assign mem_addr = mem_addr_q;
    assign mem_din  = mem_din_q;

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed bench: cache_ctrl against a 4-cycle word RAM model sharing clk/rst.
module tb_cache_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_addr, cpu_din, cpu_dout;
    logic        cpu_stall;
    logic        mem_cs, mem_we;
    logic [31:0] mem_addr, mem_din;
    logic [31:0] mem_dout;
    logic        mem_ack;
    logic        ram_init;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cache_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_din   (cpu_din),
        .cpu_dout  (cpu_dout),
        .cpu_stall (cpu_stall),
        .mem_cs    (mem_cs),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_dout  (mem_dout),
        .mem_ack   (mem_ack)
    );

    // Slow RAM: acks on the 5th cycle of mem_cs (cs seen on 4 edges, ack registered on the 4th).
    logic [31:0] ram [64];
    int          ram_cnt;

    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 64; i++) ram[i] <= 32'hC0DE_0000 | 32'(i);
            ram[4]   <= 32'hDEADBEEF;
            ram[20]  <= 32'h5050_5050;
            mem_dout <= '0;
        end
        if (rst) begin
            mem_ack <= 1'b0;
            ram_cnt <= 0;
        end else begin
            mem_ack <= 1'b0;
            if (mem_cs && !mem_ack) begin
                if (ram_cnt == 3) begin
                    mem_ack <= 1'b1;
                    ram_cnt <= 0;
                    if (mem_we) ram[mem_addr[7:2]] <= mem_din;
                    else        mem_dout <= ram[mem_addr[7:2]];
                end else begin
                    ram_cnt <= ram_cnt + 1;
                end
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One CPU access starting in cycle 0; exp_done = cycle in which stall is 0 (0 = hit, 6 = RAM access).
    task automatic access(input string name, input logic we, input logic [31:0] addr,
                          input logic [31:0] din, input logic [31:0] exp_dout, input int exp_done);
        int cyc = 0;
        int cs_first = -1;
        int cs_last = -1;
        int cs_n = 0;
        logic        seen_we = 1'b0;
        logic [31:0] seen_addr = '0;
        logic [31:0] seen_din = '0;
        logic [31:0] got_dout = '0;
        bit          done = 1'b0;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_din = din;
        while (!done) begin
            @(negedge clk);
            if (mem_cs) begin
                if (cs_first < 0) begin
                    cs_first  = cyc;
                    seen_we   = mem_we;
                    seen_addr = mem_addr;
                    seen_din  = mem_din;
                end
                cs_last = cyc;
                cs_n++;
            end
            if (!cpu_stall || cyc >= 20) begin
                got_dout = cpu_dout;
                done = 1'b1;
            end else begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        check_eq({name, "_done_cycle"}, 32'(cyc), 32'(exp_done));
        if (!we) check_eq({name, "_dout"}, got_dout, exp_dout);
        if (exp_done == 0) begin
            check_eq({name, "_cs_cycles"}, 32'(cs_n), 32'd0);
        end else begin
            check_eq({name, "_cs_first"}, 32'(cs_first), 32'd1);
            check_eq({name, "_cs_last"}, 32'(cs_last), 32'd5);
            check_eq({name, "_mem_we"}, 32'(seen_we), 32'(we));
            check_eq({name, "_mem_addr"}, seen_addr, {addr[31:2], 2'b00});
            if (we) check_eq({name, "_mem_din"}, seen_din, din);
        end
        $display("txn %-10s we=%0d addr=0x%08h done_cycle=%0d cs_cycles=%0d dout=0x%08h",
                 name, we, addr, cyc, cs_n, got_dout);
        @(posedge clk); #1;
        cpu_req = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1; ram_init = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_din = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0; ram_init = 1'b0;
        @(negedge clk);
        check_eq("rst_mem_cs", 32'(mem_cs), 32'd0);
        check_eq("rst_mem_we", 32'(mem_we), 32'd0);
        check_eq("rst_mem_addr", mem_addr, 32'd0);
        check_eq("rst_mem_din", mem_din, 32'd0);
        check_eq("rst_cpu_dout", cpu_dout, 32'd0);
        check_eq("rst_cpu_stall", 32'(cpu_stall), 32'd0);
        @(posedge clk); #1;

        access("rd10_miss", 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 6);
        access("rd10_hit", 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 0);
        access("wr10_hit", 1'b1, 32'h10, 32'h12345678, 32'h0, 6);
        check_eq("ram_word4", ram[4], 32'h12345678);
        access("rd10_hit2", 1'b0, 32'h13, 32'h0, 32'h12345678, 0);
        access("wr20_miss", 1'b1, 32'h20, 32'hA5A5A5A5, 32'h0, 6);
        check_eq("ram_word8", ram[8], 32'hA5A5A5A5);
        access("rd20_miss", 1'b0, 32'h20, 32'h0, 32'hA5A5A5A5, 6);
        access("rd50_alias", 1'b0, 32'h50, 32'h0, 32'h5050_5050, 6);
        access("rd10_evict", 1'b0, 32'h10, 32'h0, 32'h12345678, 6);
        access("rd10_hit3", 1'b0, 32'h10, 32'h0, 32'h12345678, 0);

        // Reset in cycle 3 of a read miss (0x50 misses: line 4 holds 0x10).
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h50;
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1; cpu_req = 1'b0;
        @(negedge clk);
        check_eq("abort_cs_before", 32'(mem_cs), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("abort_mem_cs", 32'(mem_cs), 32'd0);
        check_eq("abort_stall", 32'(cpu_stall), 32'd0);
        $display("txn %-10s rst in cycle 3 of read 0x00000050 mem_cs=%0d stall=%0d",
                 "abort", mem_cs, cpu_stall);
        @(posedge clk); #1;
        access("rd10_postrst", 1'b0, 32'h10, 32'h0, 32'h12345678, 6);
        access("rd10_hit4", 1'b0, 32'h10, 32'h0, 32'h12345678, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
